// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Resolves conditional branches (opcode 1100011) one cycle after execute
// presents them, and keeps a table of 2-bit saturating counters that fetch
// reads for prediction and that resolved branches train.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   in_valid, opc,       instruction presented by execute this cycle
//   funct3, rs1, rs2,    condition select and operands
//   pc, imm              branch address and sign-extended B-immediate
//   pred_taken           prediction fetch made for this branch
//   flush                kill the instruction presented this cycle
//   out_valid/out_taken/ registered resolution, valid the cycle after capture
//   out_target/out_mispredict
//   lookup_pc            fetch PC to predict
//   lookup_taken         combinational prediction (counter MSB)
module branch_resolve_unit #(
    parameter int         XLEN     = 32,
    parameter int         IDX_BITS = 6,
    parameter logic [1:0] BHT_INIT = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [6:0]      opc,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            pred_taken,
    input  logic            flush,
    output logic            out_valid,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic            out_mispredict,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_taken
);

    localparam logic [6:0]      OPC_BRANCH = 7'b1100011;
    localparam int              BHT_SIZE   = 1 << IDX_BITS;
    localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'b100};

    // Branch condition evaluation; unused encodings resolve not-taken.
    function automatic logic branch_cond(input logic [2:0]      f3,
                                         input logic [XLEN-1:0] a,
                                         input logic [XLEN-1:0] b);
        logic res;
        case (f3)
            3'b000:  res = (a == b);
            3'b001:  res = (a != b);
            3'b100:  res = ($signed(a) <  $signed(b));
            3'b101:  res = ($signed(a) >= $signed(b));
            3'b110:  res = (a <  b);
            3'b111:  res = (a >= b);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Saturating 2-bit counter step toward taken / not-taken.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr,
                                            input logic       taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return nxt;
    endfunction

    logic                accept_s;
    logic                taken_s;
    logic [XLEN-1:0]     target_s;
    logic [IDX_BITS-1:0] idx_s;
    logic [IDX_BITS-1:0] idx_r;
    logic [1:0]          bht_r [BHT_SIZE];

    // Resolution of the instruction presented this cycle.
    always_comb begin
        accept_s = in_valid && (opc == OPC_BRANCH) && !flush;
        taken_s  = branch_cond(funct3, rs1, rs2);
        // Carry out of the address add is dropped: targets wrap modulo 2**XLEN.
        target_s = taken_s ? (pc + imm) : (pc + PC_STEP);
        idx_s    = pc[IDX_BITS+1:2];
    end

    // Output stage: one-cycle registered resolution.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_taken      <= 1'b0;
            out_target     <= '0;
            out_mispredict <= 1'b0;
            idx_r          <= '0;
        end else begin
            out_valid      <= accept_s;
            out_taken      <= taken_s;
            out_target     <= target_s;
            out_mispredict <= taken_s ^ pred_taken;
            idx_r          <= idx_s;
        end
    end

    // Counter table: trained by the branch currently in the output stage,
    // regardless of whether the incoming instruction is flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_SIZE; i++) begin
                bht_r[i] <= BHT_INIT;
            end
        end else if (out_valid) begin
            bht_r[idx_r] <= ctr_step(bht_r[idx_r], out_taken);
        end else begin
            bht_r[idx_r] <= bht_r[idx_r];
        end
    end

    // Prediction reads the stored counter only, so a same-index update shows
    // up the cycle after the training edge.
    assign lookup_taken = bht_r[lookup_pc[IDX_BITS+1:2]][1];

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [6:0]  opc;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2, pc, imm;
    logic        pred_taken, flush;
    logic        out_valid, out_taken, out_mispredict;
    logic [31:0] out_target;
    logic [31:0] lookup_pc;
    logic        lookup_taken;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] ALU = 7'b0110011;

    branch_resolve_unit #(.XLEN(32), .IDX_BITS(6), .BHT_INIT(2'b01)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opc(opc), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm), .pred_taken(pred_taken),
        .flush(flush), .out_valid(out_valid), .out_taken(out_taken),
        .out_target(out_target), .out_mispredict(out_mispredict),
        .lookup_pc(lookup_pc), .lookup_taken(lookup_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] a, b, p, im;
        logic        pr, fl;
        logic        ev, et;
        logic [31:0] etg;
        logic        em;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] im,
                         input logic pr, input logic fl);
        in_valid = v; opc = op; funct3 = f3; rs1 = a; rs2 = b;
        pc = p; imm = im; pred_taken = pr; flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 7'h00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        //               v     op   f3      rs1           rs2           pc            imm           pr    fl    ev    et    target        mis
        vecs[0]  = '{1'b1, BR,  3'b000, 32'h5,        32'h5,        32'h100,      32'h20,       1'b0, 1'b0, 1'b1, 1'b1, 32'h120,      1'b1};
        vecs[1]  = '{1'b1, BR,  3'b001, 32'h5,        32'h5,        32'h200,      32'h40,       1'b0, 1'b0, 1'b1, 1'b0, 32'h204,      1'b0};
        vecs[2]  = '{1'b1, BR,  3'b100, 32'hFFFFFFFF, 32'h1,        32'h300,      32'h10,       1'b1, 1'b0, 1'b1, 1'b1, 32'h310,      1'b0};
        vecs[3]  = '{1'b1, BR,  3'b110, 32'hFFFFFFFF, 32'h1,        32'h300,      32'h10,       1'b1, 1'b0, 1'b1, 1'b0, 32'h304,      1'b1};
        vecs[4]  = '{1'b1, BR,  3'b101, 32'hFFFFFFFF, 32'h1,        32'h380,      32'h10,       1'b0, 1'b0, 1'b1, 1'b0, 32'h384,      1'b0};
        vecs[5]  = '{1'b1, BR,  3'b111, 32'hFFFFFFFF, 32'h1,        32'h400,      32'hFFFFFFF0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h3F0,      1'b0};
        vecs[6]  = '{1'b1, BR,  3'b010, 32'h3,        32'h3,        32'h500,      32'h8,        1'b1, 1'b0, 1'b1, 1'b0, 32'h504,      1'b1};
        vecs[7]  = '{1'b1, BR,  3'b011, 32'h3,        32'h3,        32'h600,      32'h8,        1'b0, 1'b0, 1'b1, 1'b0, 32'h604,      1'b0};
        vecs[8]  = '{1'b1, BR,  3'b000, 32'h1,        32'h2,        32'hFFFFFFFC, 32'h8,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0};
        vecs[9]  = '{1'b1, BR,  3'b000, 32'h0,        32'h0,        32'hFFFFFFF0, 32'h20,       1'b0, 1'b0, 1'b1, 1'b1, 32'h10,       1'b1};
        vecs[10] = '{1'b1, BR,  3'b101, 32'h7,        32'h7,        32'h700,      32'hC,        1'b1, 1'b0, 1'b1, 1'b1, 32'h70C,      1'b0};
        vecs[11] = '{1'b1, BR,  3'b100, 32'h1,        32'hFFFFFFFF, 32'h704,      32'hC,        1'b1, 1'b0, 1'b1, 1'b0, 32'h708,      1'b1};
        vecs[12] = '{1'b1, BR,  3'b111, 32'h1,        32'hFFFFFFFF, 32'h708,      32'hC,        1'b0, 1'b0, 1'b1, 1'b0, 32'h70C,      1'b0};
        vecs[13] = '{1'b1, ALU, 3'b000, 32'h5,        32'h5,        32'h800,      32'h20,       1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
        vecs[14] = '{1'b0, BR,  3'b000, 32'h5,        32'h5,        32'h804,      32'h20,       1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
        vecs[15] = '{1'b1, BR,  3'b000, 32'h5,        32'h5,        32'h808,      32'h20,       1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};

        lookup_pc = 32'h100;
        do_reset();

        // Reset state
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_taken", {31'b0, out_taken}, 32'h0);
        chk("rst_target", out_target, 32'h0);
        chk("rst_mispredict", {31'b0, out_mispredict}, 32'h0);
        chk("rst_lookup", {31'b0, lookup_taken}, 32'h0);

        // Single-cycle resolution vectors
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].v, vecs[i].op, vecs[i].f3, vecs[i].a, vecs[i].b,
                  vecs[i].p, vecs[i].im, vecs[i].pr, vecs[i].fl);
            tick();
            chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].ev});
            if (vecs[i].ev) begin
                chk($sformatf("v%0d_taken", i), {31'b0, out_taken}, {31'b0, vecs[i].et});
                chk($sformatf("v%0d_target", i), out_target, vecs[i].etg);
                chk($sformatf("v%0d_mispredict", i), {31'b0, out_mispredict}, {31'b0, vecs[i].em});
            end
        end

        // Counter training at pc 0x100: 01 -> 10 -> 11 -> 11, then not-taken -> 10
        do_reset();
        lookup_pc = 32'h100;
        drive(1'b1, BR, 3'b000, 32'h5, 32'h5, 32'h100, 32'h20, 1'b0, 1'b0);
        tick();
        chk("train_e1_valid", {31'b0, out_valid}, 32'h1);
        chk("train_e1_lookup", {31'b0, lookup_taken}, 32'h0);
        tick();
        chk("train_e2_lookup", {31'b0, lookup_taken}, 32'h1);
        tick();
        tick();
        drive(1'b1, BR, 3'b000, 32'h1, 32'h2, 32'h100, 32'h20, 1'b1, 1'b0);
        tick();
        chk("train_nt_taken", {31'b0, out_taken}, 32'h0);
        chk("train_nt_target", out_target, 32'h104);
        chk("train_nt_mispredict", {31'b0, out_mispredict}, 32'h1);
        idle();
        tick();
        chk("train_sat_lookup", {31'b0, lookup_taken}, 32'h1);
        // Second not-taken: 10 -> 01, prediction flips
        drive(1'b1, BR, 3'b000, 32'h1, 32'h2, 32'h100, 32'h20, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        chk("train_dec_lookup", {31'b0, lookup_taken}, 32'h0);

        // Back-to-back with flush on the middle branch
        do_reset();
        lookup_pc = 32'h140;
        drive(1'b1, BR, 3'b000, 32'h9, 32'h9, 32'h140, 32'h8, 1'b1, 1'b0);
        tick();
        chk("b2b_1_valid", {31'b0, out_valid}, 32'h1);
        drive(1'b1, BR, 3'b000, 32'h9, 32'h9, 32'h140, 32'h8, 1'b1, 1'b1);
        tick();
        chk("b2b_2_valid", {31'b0, out_valid}, 32'h0);
        chk("b2b_2_lookup", {31'b0, lookup_taken}, 32'h1);
        drive(1'b1, BR, 3'b001, 32'h9, 32'h9, 32'h140, 32'h8, 1'b1, 1'b0);
        tick();
        chk("b2b_3_valid", {31'b0, out_valid}, 32'h1);
        chk("b2b_3_target", out_target, 32'h144);
        chk("b2b_3_mispredict", {31'b0, out_mispredict}, 32'h1);
        idle();
        tick();
        chk("b2b_4_valid", {31'b0, out_valid}, 32'h0);
        chk("b2b_4_lookup", {31'b0, lookup_taken}, 32'h0);

        // Reset mid-stream: pending resolution dropped, counters restored
        do_reset();
        lookup_pc = 32'h100;
        drive(1'b1, BR, 3'b000, 32'h5, 32'h5, 32'h100, 32'h20, 1'b0, 1'b0);
        tick();
        tick();
        chk("rstmid_pre_lookup", {31'b0, lookup_taken}, 32'h1);
        chk("rstmid_pre_valid", {31'b0, out_valid}, 32'h1);
        rst = 1'b1;
        tick();
        chk("rstmid_valid", {31'b0, out_valid}, 32'h0);
        chk("rstmid_lookup", {31'b0, lookup_taken}, 32'h0);
        rst = 1'b0;
        idle();
        tick();
        chk("rstmid_after_valid", {31'b0, out_valid}, 32'h0);
        chk("rstmid_after_lookup", {31'b0, lookup_taken}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
